// File: rtl/memory_arbiter_if.sv
// Requester-side and memory-side signals of the two-port memory arbiter.
// The slave modport is the arbiter; master is the requesters plus memory_unit.
interface memory_arbiter_if #(
    parameter int REGSIZE = 8
);
    logic               req0, req1;
    logic [REGSIZE-1:0] addr0, addr1;
    logic [REGSIZE-1:0] wdata0, wdata1;
    logic [1:0]         ctrl0, ctrl1;
    logic               ack0, ack1;
    logic [REGSIZE-1:0] rdata0, rdata1;
    logic [REGSIZE-1:0] mem_addr_bus;
    logic [REGSIZE-1:0] mem_write_bus;
    logic [1:0]         mem_ctrl_bus;
    logic [REGSIZE-1:0] mem_read_bus;
    logic               busy;
    logic               owner;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, ctrl0, ctrl1, mem_read_bus,
        output ack0, ack1, rdata0, rdata1, mem_addr_bus, mem_write_bus, mem_ctrl_bus,
               busy, owner
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, ctrl0, ctrl1, mem_read_bus,
        input  ack0, ack1, rdata0, rdata1, mem_addr_bus, mem_write_bus, mem_ctrl_bus,
               busy, owner
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory_unit port between loader (port 0) and cpu (port 1).
// Each grant holds the memory buses for MEM_LATENCY cycles, then pulses that port's ack.
module memory_arbiter #(
    parameter int REGSIZE     = 8,
    parameter int MEM_LATENCY = 1,
    parameter bit INIT_PRIO   = 1'b0
) (
    input logic              CLOCK,
    input logic              RESET,
    memory_arbiter_if.slave  bus
);
    localparam logic [1:0] MEMORY_STAY = 2'b00;
    localparam logic [3:0] LAT_LOAD    = 4'(MEM_LATENCY - 1);

    typedef enum logic {ARB_IDLE, ARB_BUSY} state_t;

    state_t             state;
    logic               owner;
    logic               last_grant;
    logic [3:0]         lat_cnt;
    logic [REGSIZE-1:0] addr_q;
    logic [REGSIZE-1:0] wdata_q;
    logic [1:0]         ctrl_q;
    logic               ack0, ack1;
    logic [REGSIZE-1:0] rdata0, rdata1;

    logic eff0, eff1, grant, winner;

    // A port acked this cycle is masked so a still-high req is not served twice.
    always_comb begin
        eff0   = bus.req0 & ~ack0;
        eff1   = bus.req1 & ~ack1;
        grant  = eff0 | eff1;
        winner = (eff0 && eff1) ? ~last_grant : eff1;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values, regardless of statement order inside the block.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= ARB_IDLE;
            owner      <= INIT_PRIO;
            last_grant <= ~INIT_PRIO;
            lat_cnt    <= '0;
            // NOTE: the access latches are reset too, so the buses never show stale
            // requester data after a reset that aborted an access.
            addr_q     <= '0;
            wdata_q    <= '0;
            ctrl_q     <= MEMORY_STAY;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        addr_q     <= winner ? bus.addr1  : bus.addr0;
                        wdata_q    <= winner ? bus.wdata1 : bus.wdata0;
                        ctrl_q     <= winner ? bus.ctrl1  : bus.ctrl0;
                        owner      <= winner;
                        last_grant <= winner;
                        lat_cnt    <= LAT_LOAD;
                        state      <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        if (owner) begin
                            rdata1 <= bus.mem_read_bus;
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= bus.mem_read_bus;
                            ack0   <= 1'b1;
                        end
                        state <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.mem_addr_bus  = (state == ARB_BUSY) ? addr_q  : '0;
    assign bus.mem_write_bus = (state == ARB_BUSY) ? wdata_q : '0;
    assign bus.mem_ctrl_bus  = (state == ARB_BUSY) ? ctrl_q  : MEMORY_STAY;
    assign bus.busy          = (state == ARB_BUSY);
    assign bus.owner         = owner;
    assign bus.ack0          = ack0;
    assign bus.ack1          = ack1;
    assign bus.rdata0        = rdata0;
    assign bus.rdata1        = rdata1;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance at MEM_LATENCY=1, one at 3, each with
// a small memory_unit model; read data is checked through per-instance scoreboards.
module tb_memory_arbiter;
    localparam logic [1:0] STAY  = 2'b00;
    localparam logic [1:0] WRITE = 2'b01;

    typedef struct {
        logic       port;
        logic [7:0] data;
        logic       chk_data;
    } exp_t;

    logic clk = 1'b0;
    logic rst1, rst3;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb1[$];
    exp_t sb3[$];
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];

    memory_arbiter_if #(.REGSIZE(8)) if1 ();
    memory_arbiter_if #(.REGSIZE(8)) if3 ();

    memory_arbiter #(.REGSIZE(8), .MEM_LATENCY(1), .INIT_PRIO(1'b0)) dut1 (
        .CLOCK(clk), .RESET(rst1), .bus(if1)
    );
    memory_arbiter #(.REGSIZE(8), .MEM_LATENCY(3), .INIT_PRIO(1'b0)) dut3 (
        .CLOCK(clk), .RESET(rst3), .bus(if3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst1) begin
            mem1[8'h01] <= 8'h11;
            mem1[8'h02] <= 8'h22;
            mem1[8'h05] <= 8'hA7;
        end else if (if1.mem_ctrl_bus == WRITE) begin
            mem1[if1.mem_addr_bus] <= if1.mem_write_bus;
        end
    end

    always @(posedge clk) begin
        if (if3.mem_ctrl_bus == WRITE) mem3[if3.mem_addr_bus] <= if3.mem_write_bus;
    end

    assign if1.mem_read_bus = mem1[if1.mem_addr_bus];
    assign if3.mem_read_bus = mem3[if3.mem_addr_bus];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_compare(input string tag, input exp_t e, input logic port,
                              input logic [7:0] data);
        check({tag, "_port"}, 32'(port), 32'(e.port));
        if (e.chk_data) check({tag, "_rdata"}, 32'(data), 32'(e.data));
    endtask

    task automatic pop1(input string tag);
        exp_t e;
        if (sb1.size() == 0) begin
            check({tag, "_sb1_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb1.pop_front();
            sb_compare(tag, e, if1.ack1, if1.ack1 ? if1.rdata1 : if1.rdata0);
        end
    endtask

    task automatic pop3(input string tag);
        exp_t e;
        if (sb3.size() == 0) begin
            check({tag, "_sb3_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb3.pop_front();
            sb_compare(tag, e, if3.ack1, if3.ack1 ? if3.rdata1 : if3.rdata0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst1 = 1'b1;
        rst3 = 1'b1;
        {if1.req0, if1.req1, if3.req0, if3.req1} = '0;
        {if1.addr0, if1.addr1, if3.addr0, if3.addr1} = '0;
        {if1.wdata0, if1.wdata1, if3.wdata0, if3.wdata1} = '0;
        {if1.ctrl0, if1.ctrl1, if3.ctrl0, if3.ctrl1} = '0;
        tick();
        tick();
        rst1 = 1'b0;
        rst3 = 1'b0;

        // 1: idle after reset
        check("t1_owner", 32'(if1.owner), 32'd0);
        for (int c = 0; c < 20; c++) begin
            check("t1_idle", {if1.mem_ctrl_bus, if1.ack0, if1.ack1, if1.busy}, 32'd0);
            check("t1_rdata", {if1.rdata0, if1.rdata1}, 32'd0);
            tick();
        end

        // 2: single cpu read, MEM_LATENCY=1
        if1.addr1 = 8'h05;
        if1.ctrl1 = STAY;
        if1.req1  = 1'b1;
        sb1.push_back('{1'b1, 8'hA7, 1'b1});
        tick();
        check("t2_addr_t1", 32'(if1.mem_addr_bus), 32'h05);
        check("t2_busy_t1", {if1.busy, if1.owner, if1.ack1}, 32'b110);
        tick();
        check("t2_ack_t2", {if1.ack0, if1.ack1}, 32'b01);
        if (if1.ack1) pop1("t2");
        if1.req1 = 1'b0;
        tick();
        check("t2_ack_t3", {if1.ack0, if1.ack1, if1.busy}, 32'd0);

        // 3: both ports continuously after reset, strict alternation starting at INIT_PRIO
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        if1.addr0 = 8'h01;
        if1.ctrl0 = STAY;
        if1.addr1 = 8'h02;
        if1.ctrl1 = STAY;
        if1.req0  = 1'b1;
        if1.req1  = 1'b1;
        sb1.push_back('{1'b0, 8'h11, 1'b1});
        sb1.push_back('{1'b1, 8'h22, 1'b1});
        sb1.push_back('{1'b0, 8'h11, 1'b1});
        sb1.push_back('{1'b1, 8'h22, 1'b1});
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("t3_ack_c%0d", c), {if1.ack0, if1.ack1},
                  {30'd0, (c == 2 || c == 6), (c == 4 || c == 8)});
            if (if1.ack0 || if1.ack1) pop1($sformatf("t3_c%0d", c));
        end
        if1.req0 = 1'b0;
        if1.req1 = 1'b0;
        tick();
        check("t3_done", {if1.busy, if1.ack0, if1.ack1}, 32'd0);

        // 5: req0 held through its ack cycle -> exactly one access
        if1.addr0 = 8'h05;
        if1.req0  = 1'b1;
        sb1.push_back('{1'b0, 8'hA7, 1'b1});
        tick();
        tick();
        check("t5_ack", {if1.ack0, if1.ack1}, 32'b10);
        if (if1.ack0) pop1("t5");
        tick();
        check("t5_no_regrant", {if1.busy, if1.ack0}, 32'd0);
        if1.req0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_quiet", {if1.busy, if1.ack0, if1.ack1}, 32'd0);
        end
        check("t5_sb_empty", 32'(sb1.size()), 32'd0);

        // 4: write held for MEM_LATENCY=3 cycles, then cpu reads it back
        if3.addr0  = 8'h10;
        if3.wdata0 = 8'h3C;
        if3.ctrl0  = WRITE;
        if3.req0   = 1'b1;
        sb3.push_back('{1'b0, 8'h00, 1'b0});
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("t4_bus_c%0d", c),
                  {if3.mem_ctrl_bus, if3.mem_addr_bus, if3.mem_write_bus, if3.ack0},
                  {7'd0, WRITE, 8'h10, 8'h3C, 1'b0});
        end
        tick();
        check("t4_ack", {if3.ack0, if3.ack1, if3.mem_ctrl_bus}, {28'd0, 2'b10, STAY});
        if (if3.ack0) pop3("t4_write");
        if3.req0 = 1'b0;
        tick();
        if3.addr1 = 8'h10;
        if3.ctrl1 = STAY;
        if3.req1  = 1'b1;
        sb3.push_back('{1'b1, 8'h3C, 1'b1});
        n = 0;
        do begin
            tick();
            n++;
        end while (!if3.ack1 && n < 12);
        check("t4_read_latency", 32'(n), 32'd4);
        if (if3.ack1) pop3("t4_read");
        if3.req1 = 1'b0;
        tick();

        // 6: reset in the middle of a MEM_LATENCY=3 access
        if3.addr0 = 8'h20;
        if3.ctrl0 = STAY;
        if3.req0  = 1'b1;
        tick();
        check("t6_busy_t1", 32'(if3.busy), 32'd1);
        rst3 = 1'b1;
        tick();
        check("t6_idle_t2", {if3.busy, if3.mem_ctrl_bus, if3.mem_addr_bus}, {21'd0, 1'b0, STAY, 8'h00});
        rst3     = 1'b0;
        if3.req0 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("t6_no_ack", {if3.ack0, if3.ack1, if3.busy}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
